// File: rtl/qei_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module      : qei_encoder_emulator
// Description : Quadrature encoder emulator. Produces Gray-sequenced A/B
//               channels and a once-per-revolution index pulse from a
//               commanded edge period and direction. Acts as the transmit-side
//               counterpart of the quadrature decoder (on-chip loopback or
//               pad-level encoder emulation for an external drive).
//
// Parameters  : CNT_W - width of the position counter and load value
//               DIV_W - width of the rate divider and period input
//               CPR   - quadrature counts per revolution (multiple of 4,
//                       at least 8, no larger than 2**CNT_W)
//
// Ports       : sys_clk  - system clock, rising edge
//               sys_rst  - synchronous active-high reset
//               enable   - 1 = generate edges, 0 = hold outputs, clear divider
//               dir      - 0 = forward (A leads B), 1 = reverse
//               period   - sys_clk cycles per quadrature edge, 0 = stopped
//               load     - one-cycle strobe, load position from load_pos
//               load_pos - position value to load (clamped to CPR-1)
//               qei_a    - quadrature channel A (registered)
//               qei_b    - quadrature channel B (registered)
//               qei_i    - index, high while position == 0 (registered)
//               position - current position, 0..CPR-1
//               edge_stb - one-cycle pulse when an edge moves the position
//
// Revision    : 1.0 - initial release
// ============================================================================
module qei_encoder_emulator #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int CPR   = 4096
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic             dir,
    input  logic [DIV_W-1:0] period,
    input  logic             load,
    input  logic [CNT_W-1:0] load_pos,
    output logic             qei_a,
    output logic             qei_b,
    output logic             qei_i,
    output logic [CNT_W-1:0] position,
    output logic             edge_stb
);

    localparam logic [CNT_W-1:0] c_pos_zero = '0;
    localparam logic [CNT_W-1:0] c_pos_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_pos_max  = CNT_W'(CPR - 1);
    // One bit wider so that CPR == 2**CNT_W is representable.
    localparam logic [CNT_W:0]   c_cpr_ext  = (CNT_W + 1)'(CPR);
    localparam logic [DIV_W-1:0] c_div_zero = '0;
    localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);

    logic [CNT_W-1:0] r_pos;
    logic             r_a;
    logic             r_b;
    logic             r_i;
    logic             r_stb;
    logic [DIV_W-1:0] r_div;

    logic             w_run;
    logic             w_fire;
    logic [DIV_W-1:0] w_period_m1;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_step_pos;
    logic [CNT_W-1:0] w_next_pos;

    assign w_run       = enable && (period != c_div_zero);
    assign w_period_m1 = period - c_div_one;
    // A >= compare rather than == lets a shortened period fire immediately
    // instead of letting the divider run all the way round to wrap.
    assign w_fire      = w_run && (r_div >= w_period_m1);

    assign w_load_val  = ({1'b0, load_pos} >= c_cpr_ext) ? c_pos_max : load_pos;

    // dir only matters on a fire cycle, so a change between edges is harmless.
    always_comb begin
        w_step_pos = r_pos;
        if (dir) begin
            w_step_pos = (r_pos == c_pos_zero) ? c_pos_max : (r_pos - c_pos_one);
        end else begin
            w_step_pos = (r_pos == c_pos_max) ? c_pos_zero : (r_pos + c_pos_one);
        end
    end

    // Load beats a coincident fire; that edge is simply dropped.
    always_comb begin
        w_next_pos = r_pos;
        if (load) begin
            w_next_pos = w_load_val;
        end else if (w_fire) begin
            w_next_pos = w_step_pos;
        end
    end

    // A/B/I are derived from the next position so they change on the same
    // clock edge as position. The mapping A = p1^p0, B = p1 is Gray coded;
    // CPR being a multiple of 4 keeps the wrap Gray as well.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pos <= c_pos_zero;
            r_a   <= 1'b0;
            r_b   <= 1'b0;
            r_i   <= 1'b1;
            r_stb <= 1'b0;
            r_div <= c_div_zero;
        end else begin
            r_pos <= w_next_pos;
            r_a   <= w_next_pos[1] ^ w_next_pos[0];
            r_b   <= w_next_pos[1];
            r_i   <= (w_next_pos == c_pos_zero);
            r_stb <= w_fire && !load;
            if (load || w_fire || !w_run) begin
                r_div <= c_div_zero;
            end else begin
                r_div <= r_div + c_div_one;
            end
        end
    end

    assign qei_a    = r_a;
    assign qei_b    = r_b;
    assign qei_i    = r_i;
    assign position = r_pos;
    assign edge_stb = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_qei_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_qei_encoder_emulator
// Description : Scoreboard bench for qei_encoder_emulator (CPR = 8). Directed
//               stimulus pushes hand-computed edge records (cycle, position,
//               A, B, I) into a queue; a monitor pops one per edge_stb.
//               Non-edge state (reset, load) is checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qei_encoder_emulator;

    localparam int c_cnt_w = 16;
    localparam int c_div_w = 16;
    localparam int c_cpr   = 8;

    typedef struct packed {
        logic [31:0]        cyc;
        logic [c_cnt_w-1:0] pos;
        logic               a;
        logic               b;
        logic               i;
    } exp_t;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               enable;
    logic               dir;
    logic [c_div_w-1:0] period;
    logic               load;
    logic [c_cnt_w-1:0] load_pos;
    logic               qei_a;
    logic               qei_b;
    logic               qei_i;
    logic [c_cnt_w-1:0] position;
    logic               edge_stb;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t m_e;

    qei_encoder_emulator #(
        .CNT_W (c_cnt_w),
        .DIV_W (c_div_w),
        .CPR   (c_cpr)
    ) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .enable   (enable),
        .dir      (dir),
        .period   (period),
        .load     (load),
        .load_pos (load_pos),
        .qei_a    (qei_a),
        .qei_b    (qei_b),
        .qei_i    (qei_i),
        .position (position),
        .edge_stb (edge_stb)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle index: value seen at a falling edge = number of rising edges so far.
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int p, input logic a, input logic b, input logic i);
        exp_t e;
        e.cyc = 32'(c);
        e.pos = c_cnt_w'(p);
        e.a   = a;
        e.b   = b;
        e.i   = i;
        exp_q.push_back(e);
    endtask

    // Non-edge state check, used where no edge_stb is expected.
    task automatic check_state(input string name, input int p, input logic a, input logic b,
                               input logic i);
        check({name, "_pos"}, 32'(position), 32'(p));
        check({name, "_ab"},  32'({qei_a, qei_b}), 32'({a, b}));
        check({name, "_i"},   32'(qei_i), 32'(i));
        check({name, "_stb"}, 32'(edge_stb), 32'(0));
    endtask

    task automatic at_cyc(input int t);
        do @(negedge sys_clk); while (cyc < t);
    endtask

    // Monitor: every edge_stb consumes one expected record; an expected
    // record whose cycle has passed without an edge is a missed edge.
    always @(negedge sys_clk) begin
        if (edge_stb) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_edge: got edge at cyc %0d position %0d, required none",
                         cyc, position);
            end else begin
                m_e = exp_q.pop_front();
                check("edge_cyc", 32'(cyc), m_e.cyc);
                check("edge_pos", 32'(position), 32'(m_e.pos));
                check("edge_ab",  32'({qei_a, qei_b}), 32'({m_e.a, m_e.b}));
                check("edge_i",   32'(qei_i), 32'(m_e.i));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= 32'(cyc)) begin
            m_e = exp_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missed_edge: got no edge at cyc %0d, required edge to position %0d",
                     cyc, m_e.pos);
        end
    end

    initial begin
        int n;
        int m;
        sys_rst  = 1'b1;
        enable   = 1'b0;
        dir      = 1'b0;
        period   = '0;
        load     = 1'b0;
        load_pos = '0;

        // Reset state
        at_cyc(3);
        check_state("reset", 0, 1'b0, 1'b0, 1'b1);
        sys_rst = 1'b0;

        // Forward, period 4: AB 10,11,01,00; index drops after first edge
        at_cyc(5);
        n = cyc;
        enable = 1'b1; period = 16'd4; dir = 1'b0;
        push(n + 4,  1, 1'b1, 1'b0, 1'b0);
        push(n + 8,  2, 1'b1, 1'b1, 1'b0);
        push(n + 12, 3, 1'b0, 1'b1, 1'b0);
        push(n + 16, 4, 1'b0, 1'b0, 1'b0);
        at_cyc(n + 16);
        enable = 1'b0;
        at_cyc(n + 18);
        check_state("hold_fwd", 4, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_pos = 16'd0;
        at_cyc(n + 19);
        load = 1'b0;
        check_state("load0_a", 0, 1'b0, 1'b0, 1'b1);

        // period 1 across the 7 -> 0 wrap
        at_cyc(n + 20);
        n = cyc;
        enable = 1'b1; period = 16'd1;
        push(n + 1,  1, 1'b1, 1'b0, 1'b0);
        push(n + 2,  2, 1'b1, 1'b1, 1'b0);
        push(n + 3,  3, 1'b0, 1'b1, 1'b0);
        push(n + 4,  4, 1'b0, 1'b0, 1'b0);
        push(n + 5,  5, 1'b1, 1'b0, 1'b0);
        push(n + 6,  6, 1'b1, 1'b1, 1'b0);
        push(n + 7,  7, 1'b0, 1'b1, 1'b0);
        push(n + 8,  0, 1'b0, 1'b0, 1'b1);
        push(n + 9,  1, 1'b1, 1'b0, 1'b0);
        push(n + 10, 2, 1'b1, 1'b1, 1'b0);
        at_cyc(n + 10);
        enable = 1'b0;
        at_cyc(n + 12);
        load = 1'b1; load_pos = 16'd0;
        at_cyc(n + 13);
        load = 1'b0;
        check_state("load0_b", 0, 1'b0, 1'b0, 1'b1);

        // Reverse from 0, period 2: 7 (AB 01) then 6 (AB 11)
        at_cyc(n + 14);
        n = cyc;
        enable = 1'b1; period = 16'd2; dir = 1'b1;
        push(n + 2, 7, 1'b0, 1'b1, 1'b0);
        push(n + 4, 6, 1'b1, 1'b1, 1'b0);
        at_cyc(n + 4);
        enable = 1'b0;

        // Period 100 shortened to 10 with divider at 50
        at_cyc(n + 6);
        n = cyc;
        enable = 1'b1; period = 16'd100; dir = 1'b0;
        at_cyc(n + 50);
        period = 16'd10;
        push(n + 51, 7, 1'b0, 1'b1, 1'b0);
        push(n + 61, 0, 1'b0, 1'b0, 1'b1);
        push(n + 71, 1, 1'b1, 1'b0, 1'b0);
        at_cyc(n + 71);
        enable = 1'b0;

        // Load coincident with a fire, then an out-of-range load
        at_cyc(n + 73);
        n = cyc;
        enable = 1'b1; period = 16'd3;
        push(n + 3, 2, 1'b1, 1'b1, 1'b0);
        push(n + 6, 3, 1'b0, 1'b1, 1'b0);
        at_cyc(n + 8);
        load = 1'b1; load_pos = 16'd5;
        at_cyc(n + 9);
        load = 1'b0;
        check_state("load5", 5, 1'b1, 1'b0, 1'b0);
        push(n + 12, 6, 1'b1, 1'b1, 1'b0);
        at_cyc(n + 12);
        load = 1'b1; load_pos = 16'(c_cpr + 3);
        at_cyc(n + 13);
        load = 1'b0;
        check_state("load_clamp", 7, 1'b0, 1'b1, 1'b0);
        push(n + 16, 0, 1'b0, 1'b0, 1'b1);

        // Enable dropped mid-count, then period 0 while enabled
        at_cyc(n + 17);
        enable = 1'b0;
        at_cyc(n + 22);
        check_state("frozen", 0, 1'b0, 1'b0, 1'b1);
        enable = 1'b1; period = 16'd0;
        at_cyc(n + 27);
        check_state("period0", 0, 1'b0, 1'b0, 1'b1);
        enable = 1'b0; period = 16'd3;

        // Re-enable with period 3, reverse between edges, then reset
        at_cyc(n + 28);
        m = cyc;
        enable = 1'b1;
        push(m + 3, 1, 1'b1, 1'b0, 1'b0);
        at_cyc(m + 4);
        dir = 1'b1;
        push(m + 6, 0, 1'b0, 1'b0, 1'b1);
        at_cyc(m + 7);
        sys_rst = 1'b1; load = 1'b1; load_pos = 16'd3;
        at_cyc(m + 8);
        check_state("reset_run", 0, 1'b0, 1'b0, 1'b1);
        sys_rst = 1'b0; load = 1'b0;
        push(m + 11, 7, 1'b0, 1'b1, 1'b0);
        at_cyc(m + 11);
        enable = 1'b0;

        at_cyc(m + 20);
        while (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL pending_edge: got no edge, required edge at cyc %0d to position %0d",
                     m_e.cyc, m_e.pos);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
